// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues ALU commands and issues one per cycle
// to the register-file/ALU datapath, returning the zero flag.
module alu_op_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [4:0]       cmd_rd,
  input  logic [4:0]       cmd_rs1,
  input  logic [4:0]       cmd_rs2,
  output logic [4:0]       rr1,
  output logic [4:0]       rr2,
  output logic [4:0]       wr,
  output logic             rw,
  output logic [3:0]       ctl,
  input  logic             zero,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_zero,
  output logic [2:0]       resp_op,
  output logic             err,
  output logic [CNT_W-1:0] op_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    HOLD
  } state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } cmd_t;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count, count_nxt;
  logic          live;
  logic          push, pop;
  logic          legal, blocked, fire, load;
  state_t        state, state_nxt;

  assign head      = mem[rptr];
  assign cmd_ready = live && (count != CNT_FULL);
  assign push      = cmd_valid && cmd_ready;
  assign legal     = (head.op <= 3'd4);
  assign blocked   = resp_valid && !resp_ready && legal;
  assign fire      = (state == EXEC) && !blocked;
  assign pop       = fire;
  assign load      = fire && legal;
  assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);

  // Command storage; contents need no reset, pointers guard them
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {cmd_op, cmd_rd, cmd_rs1, cmd_rs2};
  end

  // FIFO pointers, occupancy and post-reset ready enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      live  <= 1'b0;
    end else begin
      live  <= 1'b1;
      count <= count_nxt;
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state and datapath drive from the head entry
  always_comb begin
    state_nxt = state;
    rr1       = 5'd0;
    rr2       = 5'd0;
    wr        = 5'd0;
    rw        = 1'b0;
    ctl       = 4'b0000;
    unique case (state)
      IDLE: begin
        if (count_nxt != '0) state_nxt = EXEC;
      end
      EXEC: begin
        if (blocked) begin
          state_nxt = HOLD;
        end else begin
          rr1 = head.rs1;
          rr2 = head.rs2;
          wr  = head.rd;
          unique case (head.op)
            3'd0: begin ctl = 4'b0010; rw = 1'b1; end
            3'd1: begin ctl = 4'b0110; rw = 1'b1; end
            3'd2: begin ctl = 4'b0000; rw = 1'b1; end
            3'd3: begin ctl = 4'b0001; rw = 1'b1; end
            3'd4: begin ctl = 4'b0110; rw = 1'b0; end
            default: begin ctl = 4'b0000; rw = 1'b0; end
          endcase
          state_nxt = (count_nxt != '0) ? EXEC : IDLE;
        end
      end
      HOLD: begin
        if (resp_ready)
          state_nxt = (count_nxt != '0) ? EXEC : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Response register, sticky error and completion counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid <= 1'b0;
      resp_zero  <= 1'b0;
      resp_op    <= 3'd0;
      err        <= 1'b0;
      op_count   <= '0;
    end else begin
      if (load) begin
        resp_valid <= 1'b1;
        resp_zero  <= zero;
        resp_op    <= head.op;
        op_count   <= op_count + CNT_W'(1);
      end else if (resp_ready) begin
        resp_valid <= 1'b0;
      end
      if (fire && !legal) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: datapath model plus response scoreboard
// around alu_op_sequencer.
module tb_alu_op_sequencer;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_CEQ = 3'd4;
  localparam logic [2:0] OP_BAD = 3'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [4:0]  cmd_rd, cmd_rs1, cmd_rs2;
  logic [4:0]  rr1, rr2, wr;
  logic        rw;
  logic [3:0]  ctl;
  logic        zero;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_zero;
  logic [2:0]  resp_op;
  logic        err;
  logic [15:0] op_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] regs [32];
  logic [31:0] mreg [32];
  logic [31:0] alu;
  logic        dp_load;

  logic [3:0]  sb [$];
  int          exp_count = 0;
  logic        exp_err = 1'b0;

  typedef struct {
    int         cyc;
    logic [3:0] ctl;
    logic [4:0] wr;
    logic       rw;
  } ev_t;
  ev_t trace_q [$];
  ev_t ev_tmp;
  logic [3:0] got_resp;

  alu_op_sequencer #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .rr1(rr1), .rr2(rr2), .wr(wr), .rw(rw), .ctl(ctl),
    .zero(zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_zero(resp_zero), .resp_op(resp_op),
    .err(err), .op_count(op_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath: combinational ALU, register file written at the edge
  always_comb begin
    alu = 32'd0;
    case (ctl)
      4'b0000: alu = regs[rr1] & regs[rr2];
      4'b0001: alu = regs[rr1] | regs[rr2];
      4'b0010: alu = regs[rr1] + regs[rr2];
      4'b0110: alu = regs[rr1] - regs[rr2];
      default: alu = 32'd0;
    endcase
  end
  assign zero = (alu == 32'd0);

  always @(posedge clk) begin
    if (dp_load) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'(i);
    end else if (rw && wr != 5'd0) begin
      regs[wr] <= alu;
    end
  end

  // Issue trace and response scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      if (rw || ctl != 4'd0) begin
        ev_tmp.cyc = cyc;
        ev_tmp.ctl = ctl;
        ev_tmp.wr  = wr;
        ev_tmp.rw  = rw;
        trace_q.push_back(ev_tmp);
      end
      if (resp_valid && resp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL resp_unexpected got op=%0d zero=%0b expected none",
                   resp_op, resp_zero);
        end else begin
          got_resp = sb.pop_front();
          if ({resp_op, resp_zero} !== got_resp) begin
            failures++;
            $display("FAIL resp got op=%0d zero=%0b expected op=%0d zero=%0b",
                     resp_op, resp_zero, got_resp[3:1], got_resp[0]);
          end
        end
      end
    end
  end

  function automatic logic [31:0] alu_m(input logic [2:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      default: return a - b;
    endcase
  endfunction

  task automatic model_push(input logic [2:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2);
    logic [31:0] r;
    if (op > OP_CEQ) begin
      exp_err = 1'b1;
    end else begin
      r = alu_m(op, mreg[rs1], mreg[rs2]);
      if (op != OP_CEQ && rd != 5'd0) mreg[rd] = r;
      sb.push_back({op, (r == 32'd0)});
      exp_count++;
    end
  endtask

  task automatic try_send(input logic [2:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input int limit, output bit ok);
    ok = 1'b0;
    cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    cmd_valid = 1'b1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        model_push(op, rd, rs1, rs2);
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2);
    bit ok;
    try_send(op, rd, rs1, rs2, 50, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_timeout got cmd_ready=0 for 50 cycles required accept");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) break;
    end
    @(posedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending responses required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    dp_load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      cmd_valid  = 1'($urandom);
      cmd_op     = 3'($urandom);
      cmd_rd     = 5'($urandom);
      cmd_rs1    = 5'($urandom);
      cmd_rs2    = 5'($urandom);
      resp_ready = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({cmd_ready, rw, rr1, rr2, wr, ctl, resp_valid, resp_zero,
           resp_op, err, op_count} !== '0) begin
        failures++;
        $display("FAIL reset_outputs got rdy=%0b rw=%0b ctl=%0h rv=%0b err=%0b cnt=%0d required all 0",
                 cmd_ready, rw, ctl, resp_valid, err, op_count);
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    resp_ready = 1'b1;
    dp_load = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) mreg[i] = 32'(i);
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1 || rw !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got rdy=%0b rw=%0b required rdy=1 rw=0",
               cmd_ready, rw);
    end
  endtask

  task automatic test_alu_seq();
    logic [3:0] ectl [3];
    logic [4:0] ewr [3];
    ectl = '{4'b0010, 4'b0110, 4'b0001};
    ewr  = '{5'd1, 5'd4, 5'd1};
    trace_q.delete();
    send(OP_ADD, 5'd1, 5'd2, 5'd3);
    send(OP_SUB, 5'd4, 5'd5, 5'd6);
    send(OP_OR,  5'd1, 5'd4, 5'd1);
    drain();
    checks++;
    if (trace_q.size() != 3) begin
      failures++;
      $display("FAIL seq_issue_count got %0d required 3", trace_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (trace_q[i].ctl !== ectl[i] || trace_q[i].wr !== ewr[i] ||
            trace_q[i].rw !== 1'b1 ||
            (i > 0 && trace_q[i].cyc != trace_q[i-1].cyc + 1)) begin
          failures++;
          $display("FAIL seq_issue%0d got ctl=%b wr=%0d rw=%0b cyc=%0d required ctl=%b wr=%0d rw=1 consecutive",
                   i, trace_q[i].ctl, trace_q[i].wr, trace_q[i].rw,
                   trace_q[i].cyc, ectl[i], ewr[i]);
        end
      end
    end
    checks++;
    if (op_count !== 16'd3) begin
      failures++;
      $display("FAIL seq_op_count got %0d required 3", op_count);
    end
    checks++;
    if (regs[1] !== mreg[1] || regs[1] !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL seq_x1 got %h required %h", regs[1], mreg[1]);
    end
  endtask

  task automatic test_cmpeq();
    trace_q.delete();
    send(OP_CEQ, 5'd9, 5'd0, 5'd0);
    send(OP_CEQ, 5'd9, 5'd5, 5'd7);
    drain();
    checks++;
    if (trace_q.size() != 2) begin
      failures++;
      $display("FAIL cmpeq_issue_count got %0d required 2", trace_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (trace_q[i].ctl !== 4'b0110 || trace_q[i].rw !== 1'b0) begin
          failures++;
          $display("FAIL cmpeq_issue%0d got ctl=%b rw=%0b required ctl=0110 rw=0",
                   i, trace_q[i].ctl, trace_q[i].rw);
        end
      end
    end
    checks++;
    if (regs[9] !== 32'd9 || regs[5] !== 32'd5 || regs[7] !== 32'd7) begin
      failures++;
      $display("FAIL cmpeq_regs got x9=%0d x5=%0d x7=%0d required 9 5 7",
               regs[9], regs[5], regs[7]);
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] ops [6];
    logic [4:0] s1 [6];
    logic [4:0] s2 [6];
    bit ok;
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADD, OP_SUB};
    s1  = '{5'd2, 5'd5, 5'd6, 5'd0, 5'd3, 5'd8};
    s2  = '{5'd3, 5'd5, 5'd9, 5'd0, 5'd3, 5'd2};
    resp_ready = 1'b0;
    trace_q.delete();
    for (int i = 0; i < 5; i++) send(ops[i], 5'(10 + i), s1[i], s2[i]);
    try_send(ops[5], 5'd15, s1[5], s2[5], 4, ok);
    checks++;
    if (ok) begin
      failures++;
      $display("FAIL bp_sixth_push got accepted required refused");
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || rw !== 1'b0 || resp_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_hold got rdy=%0b rw=%0b rv=%0b required 0 0 1",
               cmd_ready, rw, resp_valid);
    end
    checks++;
    if (resp_op !== OP_ADD || sb.size() != 5 || trace_q.size() != 1) begin
      failures++;
      $display("FAIL bp_held got op=%0d pending=%0d issued=%0d required 0 5 1",
               resp_op, sb.size(), trace_q.size());
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    drain();
    checks++;
    if (trace_q.size() != 5) begin
      failures++;
      $display("FAIL bp_drain_count got %0d required 5", trace_q.size());
    end else begin
      checks++;
      if (trace_q[2].cyc != trace_q[1].cyc + 1 ||
          trace_q[3].cyc != trace_q[2].cyc + 1 ||
          trace_q[4].cyc != trace_q[3].cyc + 1) begin
        failures++;
        $display("FAIL bp_drain_rate got cycles %0d %0d %0d %0d required consecutive",
                 trace_q[1].cyc, trace_q[2].cyc, trace_q[3].cyc, trace_q[4].cyc);
      end
    end
    send(ops[5], 5'd15, s1[5], s2[5]);
    drain();
    for (int r = 10; r < 16; r++) begin
      checks++;
      if (regs[r] !== mreg[r]) begin
        failures++;
        $display("FAIL bp_reg x%0d got %h required %h", r, regs[r], mreg[r]);
      end
    end
  endtask

  task automatic test_illegal();
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL illegal_pre_err got %0b required 0", err);
    end
    trace_q.delete();
    send(OP_ADD, 5'd20, 5'd2, 5'd3);
    send(OP_BAD, 5'd21, 5'd2, 5'd3);
    send(OP_ADD, 5'd22, 5'd20, 5'd3);
    drain();
    checks++;
    if (err !== exp_err || err !== 1'b1) begin
      failures++;
      $display("FAIL illegal_err got %0b required 1", err);
    end
    checks++;
    if (op_count !== 16'(exp_count)) begin
      failures++;
      $display("FAIL illegal_op_count got %0d required %0d", op_count, exp_count);
    end
    checks++;
    if (trace_q.size() != 2 || regs[21] !== 32'd21 ||
        regs[20] !== 32'd5 || regs[22] !== 32'd8) begin
      failures++;
      $display("FAIL illegal_regs got issued=%0d x20=%0d x21=%0d x22=%0d required 2 5 21 8",
               trace_q.size(), regs[20], regs[21], regs[22]);
    end
  endtask

  task automatic test_reset_mid_exec();
    resp_ready = 1'b1;
    cmd_op = OP_ADD; cmd_rd = 5'd25; cmd_rs1 = 5'd2; cmd_rs2 = 5'd3;
    cmd_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL rexec_ready got %0b required 1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    #1;
    checks++;
    if (rw !== 1'b1 || wr !== 5'd25) begin
      failures++;
      $display("FAIL rexec_issue got rw=%0b wr=%0d required 1 25", rw, wr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rw !== 1'b0 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rexec_async got rw=%0b rv=%0b required 0 0", rw, resp_valid);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_count = 0;
    exp_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rw !== 1'b0 || resp_valid !== 1'b0) begin
        failures++;
        $display("FAIL rexec_after%0d got rw=%0b rv=%0b required 0 0",
                 i, rw, resp_valid);
      end
    end
    checks++;
    if (regs[25] !== 32'd25 || op_count !== 16'(exp_count) ||
        err !== exp_err || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL rexec_state got x25=%0d cnt=%0d err=%0b rdy=%0b required 25 0 0 1",
               regs[25], op_count, err, cmd_ready);
    end
  endtask

  initial begin
    cmd_valid = 1'b0;
    cmd_op = 3'd0; cmd_rd = 5'd0; cmd_rs1 = 5'd0; cmd_rs2 = 5'd0;
    resp_ready = 1'b0;
    test_reset();
    test_alu_seq();
    test_cmpeq();
    test_backpressure();
    test_illegal();
    test_reset_mid_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command-driven controller for the register-file/ALU datapath (read ports rr1/rr2, write port wr/rw, 4-bit ALU control ctl, zero flag). It accepts R-type-style operation commands over a valid/ready handshake, buffers them in a 4-entry FIFO, and issues one operation per cycle to the datapath. For every operation it returns a response carrying the sampled zero flag, and it stalls when that response is not accepted. It sits between the instruction source (decoder or testbench driver) and the datapath.

## Interface
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- CNT_W, 16, width of the completed-operation counter
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept (= !full)
- cmd_op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 CMPEQ, 101–111 illegal
- cmd_rd / cmd_rs1 / cmd_rs2  in  5 each  destination / source register indices
- rr1, rr2  out  5  datapath read addresses
- wr  out  5  datapath write address
- rw  out  1  datapath write enable
- ctl  out  4  ALU control: AND 0000, OR 0001, ADD 0010, SUB 0110
- zero  in  1  ALU zero flag from datapath (combinational from rr1/rr2/ctl)
- resp_valid  out  1  response register full
- resp_ready  in  1  consumer accepts response
- resp_zero  out  1  zero flag sampled for that op
- resp_op  out  3  op code of the completed command
- err  out  1  sticky: an illegal op was consumed
- op_count  out  CNT_W  completed (legal) ops, wraps modulo 2^CNT_W

## Operation
- FIFO: push on cmd_valid && cmd_ready; pop when FSM leaves EXEC for that entry. cmd_ready ignores same-cycle pop (full ⇒ not ready even if popping).
- FSM states: IDLE, EXEC, HOLD.
- IDLE: all datapath outputs 0 (rr1=rr2=wr=0, ctl=0000, rw=0). FIFO non-empty → EXEC next cycle.
- EXEC: drive head entry: rr1=rs1, rr2=rs2, wr=rd, ctl per op; rw=1 for ADD/SUB/AND/OR, rw=0 for CMPEQ (ctl=0110). At the end of the cycle: pop, load response (resp_zero=zero, resp_op=op), increment op_count. Next: EXEC if FIFO still non-empty after pop, else IDLE.
- Illegal op in EXEC: rw=0, ctl=0000, popped, err set, no response, op_count unchanged.
- Response register: when resp_valid=1 && resp_ready=0, FSM must not enter/remain in EXEC with a legal op; it goes to HOLD (datapath outputs as IDLE, rw=0). HOLD → EXEC (FIFO non-empty) or IDLE when the response is accepted.
- Response accept and new response load in the same cycle is allowed (throughput 1 op/cycle with resp_ready=1).
- err cleared only by reset.

## Timing
- Reset (rst=0): immediately and asynchronously: FSM=IDLE, FIFO empty, cmd_ready=0 while in reset then 1 on first cycle after release, rw=0, rr1/rr2/wr/ctl=0, resp_valid=0, resp_zero=0, resp_op=0, err=0, op_count=0.
- Reset mid-EXEC: rw drops at once; no write occurs, no response; queued commands discarded.
- Latency: command pushed at edge N → EXEC in cycle N..N+1 (datapath write at edge N+1) → resp_valid=1 after edge N+1. Empty-FIFO command: 1 cycle to issue, 2 edges to response.
- Dependent back-to-back ops need no bubble: the register file writes at the edge ending EXEC and the next op reads the updated value.
- Full FIFO with simultaneous push attempt: push refused (cmd_ready=0); no entry lost or overwritten.
- Pointer wrap: DEPTH-entry circular buffer, count 0..DEPTH.

## Test plan
- Reset: hold rst=0 with random inputs → all outputs at reset values; release → cmd_ready=1, rw=0.
- Sequence x1=x2+x3, x4=x5−x6, x1=x4|x1 issued back-to-back → ctl 0010/0110/0001, wr 1/4/1, rw=1 on three consecutive cycles, three responses, op_count=3, final x1 matches the reference model.
- CMPEQ rs1=0 rs2=0 → rw=0, ctl=0110, resp_zero=1; CMPEQ on registers holding 5 and 7 → resp_zero=0, no register changed.
- resp_ready=0 with 6 commands offered → 1 response held, FIFO fills to 4, cmd_ready=0, FSM in HOLD with rw=0; raise resp_ready → remaining ops drain at 1/cycle in order, no loss or duplication.
- cmd_op=101 between two ADDs → err=1, no write, no response, op_count=2, ADDs unaffected.
- Assert rst low during EXEC of a queued ADD → rw falls asynchronously, target register unchanged, FIFO empty after release.
